// File: rtl/hpc1_rand_gen_pkg.sv
// rtl/hpc1_rand_gen_pkg.sv - shared constants and helpers for the HPC1 randomness source
package hpc1_rand_gen_pkg;

    localparam int RAND_LFSR_WIDTH = 64;
    localparam int RAND_SEED_WIDTH = 32;

    // Feedback taps at bits 63, 62, 60 and 59.
    localparam logic [RAND_LFSR_WIDTH-1:0] RAND_LFSR_TAPS = 64'hD800_0000_0000_0000;

    // Number of pairwise cross terms between n shares.
    function automatic int num_quad(input int n);
        return (n * (n - 1)) / 2;
    endfunction

endpackage

// File: rtl/hpc1_rand_gen_if.sv
// rtl/hpc1_rand_gen_if.sv - seed handshake and randomness draw signals of hpc1_rand_gen
interface hpc1_rand_gen_if import hpc1_rand_gen_pkg::*; #(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 2
);

    logic [RAND_SEED_WIDTH-1:0]             in_seed;
    logic                                   in_seed_valid;
    logic                                   out_seed_ready;
    logic                                   in_take;
    logic                                   out_valid;
    logic [NUM_SHARES*BIT_WIDTH-1:0]        out_r;
    logic [num_quad(NUM_SHARES)*BIT_WIDTH-1:0] out_p;
    logic                                   out_refresh_req;

    modport master (
        output in_seed, in_seed_valid, in_take,
        input  out_seed_ready, out_valid, out_r, out_p, out_refresh_req
    );

    modport slave (
        input  in_seed, in_seed_valid, in_take,
        output out_seed_ready, out_valid, out_r, out_p, out_refresh_req
    );

endinterface

// File: rtl/hpc1_rand_gen_lfsr_advance.sv
// rtl/hpc1_rand_gen_lfsr_advance.sv - combinational STEPS-step successor of the 64-bit Fibonacci LFSR
module lfsr_advance import hpc1_rand_gen_pkg::*; #(
    parameter int STEPS = 1
) (
    input  logic [RAND_LFSR_WIDTH-1:0] state_i,
    output logic [RAND_LFSR_WIDTH-1:0] state_o
);

    logic [RAND_LFSR_WIDTH-1:0] acc;

    always_comb begin
        acc = state_i;
        for (int i = 0; i < STEPS; i++) begin
            acc = {acc[RAND_LFSR_WIDTH-2:0], ^(acc & RAND_LFSR_TAPS)};
        end
    end

    assign state_o = acc;

endmodule

// File: rtl/hpc1_rand_gen.sv
// rtl/hpc1_rand_gen.sv - seeded LFSR randomness source for HPC1 reshare/cross-term masks
// Optional reseed request counter enabled by defining HPC1_RAND_REFRESH_EN.
module hpc1_rand_gen import hpc1_rand_gen_pkg::*; #(
    parameter int NUM_SHARES     = 2,
    parameter int BIT_WIDTH      = 2,
    parameter int WARMUP_CYCLES  = 16,
    parameter int REFRESH_PERIOD = 1024
) (
    input  logic          in_clock,
    input  logic          in_reset,
    hpc1_rand_gen_if.slave rif
);

    localparam int R_BITS   = NUM_SHARES * BIT_WIDTH;
    localparam int OUT_BITS = (NUM_SHARES + num_quad(NUM_SHARES)) * BIT_WIDTH;
    localparam int CNT_W    = $clog2(WARMUP_CYCLES + 1);
    localparam logic [CNT_W-1:0] WARMUP_LAST = CNT_W'(WARMUP_CYCLES - 1);

    if (OUT_BITS > RAND_LFSR_WIDTH || WARMUP_CYCLES < 1) begin : g_bad_cfg
        $error("hpc1_rand_gen: need OUT_BITS <= 64 and WARMUP_CYCLES >= 1");
    end

    typedef enum logic [1:0] {S_UNSEEDED, S_LOAD, S_WARMUP, S_RUN} state_t;

    state_t                     state_q;
    logic [RAND_LFSR_WIDTH-1:0] s_q;
    logic [CNT_W-1:0]           warm_cnt_q;
    logic                       valid_q;
    logic                       seed_ready_q;

    logic [RAND_LFSR_WIDTH-1:0] s_adv_d;
    logic [RAND_LFSR_WIDTH-1:0] seed_shift_d;
    logic [RAND_LFSR_WIDTH-1:0] seed_load_d;
    logic                       xfer;

    assign xfer         = rif.in_seed_valid && seed_ready_q;
    assign seed_shift_d = {s_q[RAND_SEED_WIDTH-1:0], rif.in_seed};
    // An all-zero state would lock the LFSR forever.
    assign seed_load_d  = (seed_shift_d == '0) ? RAND_LFSR_WIDTH'(1) : seed_shift_d;

    lfsr_advance #(.STEPS(OUT_BITS)) u_adv (
        .state_i (s_q),
        .state_o (s_adv_d)
    );

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            state_q      <= S_UNSEEDED;
            s_q          <= '0;
            warm_cnt_q   <= '0;
            valid_q      <= 1'b0;
            seed_ready_q <= 1'b1;
        end else begin
            case (state_q)
                S_UNSEEDED: begin
                    if (xfer) begin
                        s_q     <= seed_shift_d;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        s_q          <= seed_load_d;
                        warm_cnt_q   <= '0;
                        seed_ready_q <= 1'b0;
                        state_q      <= S_WARMUP;
                    end
                end
                S_WARMUP: begin
                    s_q <= s_adv_d;
                    if (warm_cnt_q == WARMUP_LAST) begin
                        valid_q      <= 1'b1;
                        seed_ready_q <= 1'b1;
                        state_q      <= S_RUN;
                    end else begin
                        warm_cnt_q <= warm_cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    // A reseed wins over a same-cycle draw.
                    if (xfer) begin
                        s_q     <= seed_shift_d;
                        valid_q <= 1'b0;
                        state_q <= S_LOAD;
                    end else if (rif.in_take) begin
                        s_q <= s_adv_d;
                    end
                end
                default: begin
                    state_q      <= S_UNSEEDED;
                    valid_q      <= 1'b0;
                    seed_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign rif.out_valid      = valid_q;
    assign rif.out_seed_ready = seed_ready_q;
    assign rif.out_r          = s_q[R_BITS-1:0];
    assign rif.out_p          = s_q[OUT_BITS-1:R_BITS];

`ifdef HPC1_RAND_REFRESH_EN
    localparam int DCW = $clog2(REFRESH_PERIOD + 1);
    localparam logic [DCW-1:0] REFRESH_AT = DCW'(REFRESH_PERIOD);

    if (REFRESH_PERIOD < 1) begin : g_bad_period
        $error("hpc1_rand_gen: REFRESH_PERIOD must be >= 1");
    end

    logic [DCW-1:0] draw_cnt_q;
    logic           refresh_q;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            draw_cnt_q <= '0;
            refresh_q  <= 1'b0;
        end else if (xfer) begin
            draw_cnt_q <= '0;
            refresh_q  <= 1'b0;
        end else if (valid_q && rif.in_take && !refresh_q) begin
            draw_cnt_q <= draw_cnt_q + 1'b1;
            if (draw_cnt_q + 1'b1 == REFRESH_AT) begin
                refresh_q <= 1'b1;
            end
        end
    end

    assign rif.out_refresh_req = refresh_q;
`else
    if (REFRESH_PERIOD < 1) begin : g_bad_period
        $error("hpc1_rand_gen: REFRESH_PERIOD must be >= 1");
    end

    assign rif.out_refresh_req = 1'b0;
`endif

endmodule

// File: tb/tb_hpc1_rand_gen.sv
// tb/tb_hpc1_rand_gen.sv - scoreboard bench for hpc1_rand_gen against a software LFSR model
module tb_hpc1_rand_gen;
    import hpc1_rand_gen_pkg::*;

    localparam int NS = 2;
    localparam int BW = 2;
    localparam int WU = 16;
    localparam int RP = 4;
    localparam int OB = (NS + num_quad(NS)) * BW;

`ifdef HPC1_RAND_REFRESH_EN
    localparam logic REFRESH_ON = 1'b1;
`else
    localparam logic REFRESH_ON = 1'b0;
`endif

    logic in_clock = 1'b0;
    logic in_reset = 1'b1;

    hpc1_rand_gen_if #(.NUM_SHARES(NS), .BIT_WIDTH(BW)) rif();

    hpc1_rand_gen #(
        .NUM_SHARES(NS), .BIT_WIDTH(BW), .WARMUP_CYCLES(WU), .REFRESH_PERIOD(RP)
    ) dut (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .rif      (rif)
    );

    always #5 in_clock = ~in_clock;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] model_s;
    logic [63:0] exp_q[$];

    function automatic logic [63:0] step1(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    function automatic logic [63:0] advance(input logic [63:0] s);
        logic [63:0] t;
        t = s;
        for (int i = 0; i < OB; i++) t = step1(t);
        return t;
    endfunction

    function automatic logic [63:0] word_of(input logic [63:0] s);
        return s & ((64'd1 << OB) - 64'd1);
    endfunction

    function automatic logic [63:0] dut_word();
        return 64'({rif.out_p, rif.out_r});
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clock);
        #1;
    endtask

    task automatic sb_check(input string tag);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", tag, dut_word());
        end else begin
            check_eq(tag, dut_word(), exp_q.pop_front());
        end
    endtask

    task automatic send_seed(input logic [31:0] w0, input logic [31:0] w1);
        rif.in_seed_valid = 1'b1;
        rif.in_seed       = w0;
        tick();
        rif.in_seed       = w1;
        tick();
        rif.in_seed_valid = 1'b0;
        model_s = {w0, w1};
        if (model_s == 64'd0) model_s = 64'd1;
        exp_q.delete();
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!rif.out_valid && n < 200) begin
            tick();
            n++;
        end
        check_eq({tag, "_valid_seen"}, 64'(rif.out_valid), 64'd1);
        check_eq({tag, "_latency"}, 64'(n), 64'(WU));
        for (int i = 0; i < WU; i++) model_s = advance(model_s);
        exp_q.push_back(word_of(model_s));
    endtask

    task automatic run_draws(input string tag, input int n, input logic take);
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_valid"}, 64'(rif.out_valid), 64'd1);
            sb_check({tag, "_word"});
            rif.in_take = take;
            tick();
            rif.in_take = 1'b0;
            if (take) model_s = advance(model_s);
            exp_q.push_back(word_of(model_s));
        end
    endtask

    task automatic async_reset(input string tag);
        @(posedge in_clock);
        #3;
        in_reset = 1'b1;
        #1;
        check_eq({tag, "_valid"}, 64'(rif.out_valid), 64'd0);
        check_eq({tag, "_ready"}, 64'(rif.out_seed_ready), 64'd1);
        check_eq({tag, "_word"}, dut_word(), 64'd0);
        #2;
        in_reset = 1'b0;
        tick();
    endtask

    initial begin
        rif.in_seed       = '0;
        rif.in_seed_valid = 1'b0;
        rif.in_take       = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", 64'(rif.out_valid), 64'd0);
        check_eq("rst_ready", 64'(rif.out_seed_ready), 64'd1);
        check_eq("rst_word", dut_word(), 64'd0);
        check_eq("rst_refresh", 64'(rif.out_refresh_req), 64'd0);
        in_reset = 1'b0;
        tick();

        // All-zero seed must be forced to state 1.
        send_seed(32'h0000_0000, 32'h0000_0000);
        check_eq("zero_warm_ready", 64'(rif.out_seed_ready), 64'd0);
        wait_valid("zero");
        run_draws("zero", 3, 1'b1);

        async_reset("arst");
        check_eq("arst_still_unseeded", 64'(rif.out_valid), 64'd0);

        send_seed(32'h1234_5678, 32'h9ABC_DEF0);
        wait_valid("seq");
        run_draws("seq", 100, 1'b1);
        run_draws("hold", 10, 1'b0);

        // Reseed with a same-cycle take; take is also left high through warmup.
        rif.in_take       = 1'b1;
        rif.in_seed_valid = 1'b1;
        rif.in_seed       = 32'hCAFE_F00D;
        tick();
        check_eq("reseed_valid_drop", 64'(rif.out_valid), 64'd0);
        check_eq("reseed_word", dut_word(), word_of(64'hCAFE_F00D));
        rif.in_seed       = 32'h0BAD_BEEF;
        tick();
        rif.in_seed_valid = 1'b0;
        model_s = {32'hCAFE_F00D, 32'h0BAD_BEEF};
        exp_q.delete();
        wait_valid("reseed");
        run_draws("reseed", 5, 1'b1);

        send_seed(32'hA5A5_0001, 32'h5A5A_0002);
        repeat (5) tick();
        async_reset("warm_rst");
        repeat (WU + 4) tick();
        check_eq("warm_rst_no_valid", 64'(rif.out_valid), 64'd0);

        // Partial seed discarded by reset: exactly two further transfers reach warmup.
        rif.in_seed_valid = 1'b1;
        rif.in_seed       = 32'hDEAD_0000;
        tick();
        rif.in_seed_valid = 1'b0;
        async_reset("load_rst");
        rif.in_seed_valid = 1'b1;
        rif.in_seed       = 32'h1111_2222;
        tick();
        rif.in_seed_valid = 1'b0;
        check_eq("one_xfer_ready", 64'(rif.out_seed_ready), 64'd1);
        rif.in_seed_valid = 1'b1;
        rif.in_seed       = 32'h3333_4444;
        tick();
        rif.in_seed_valid = 1'b0;
        check_eq("two_xfer_ready", 64'(rif.out_seed_ready), 64'd0);
        model_s = {32'h1111_2222, 32'h3333_4444};
        exp_q.delete();
        wait_valid("post_rst");
        run_draws("post_rst", 3, 1'b1);

        send_seed(32'h7777_8888, 32'h9999_AAAA);
        wait_valid("refr");
        for (int i = 0; i < RP; i++) begin
            check_eq("refr_low", 64'(rif.out_refresh_req), 64'd0);
            run_draws("refr", 1, 1'b1);
        end
        check_eq("refr_set", 64'(rif.out_refresh_req), 64'(REFRESH_ON));
        run_draws("refr_cont", 3, 1'b1);
        check_eq("refr_held", 64'(rif.out_refresh_req), 64'(REFRESH_ON));
        rif.in_seed_valid = 1'b1;
        rif.in_seed       = 32'h0000_1234;
        tick();
        check_eq("refr_clear", 64'(rif.out_refresh_req), 64'd0);
        tick();
        rif.in_seed_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hpc1_rand_gen.md
Name: hpc1_rand_gen

Overview:
- Fresh-randomness source feeding the HPC1 multiplier's reshare and cross-term inputs.
- Produces one full randomness word per draw: NUM_SHARES refresh masks plus num_quad(NUM_SHARES) pairwise masks, each BIT_WIDTH bits.
- Backed by a 64-bit Fibonacci LFSR that is seeded over a word-wide valid/ready handshake, warmed up, then advanced on every consumer draw.
- Sits beside each masked S-box stage and drives the multiplier randomness ports directly.

Parameters:
NUM_SHARES, 2, number of shares of the masked multiplier served
BIT_WIDTH, 2, width of one share element (T)
WARMUP_CYCLES, 16, LFSR advance cycles after seeding before output is valid (>=1)
REFRESH_PERIOD, 1024, draws between reseed requests (optional feature only, >=1)

Ports:
in_clock  input  1  clock
in_reset  input  1  asynchronous active-high reset
in_seed  input  32  seed word
in_seed_valid  input  1  seed word present
out_seed_ready  output  1  seed word accepted when high with in_seed_valid
in_take  input  1  consumer draws the current randomness word this cycle
out_valid  output  1  out_r/out_p hold a valid draw
out_r  output  NUM_SHARES*BIT_WIDTH  refresh masks, T[NUM_SHARES-1:0]
out_p  output  num_quad(NUM_SHARES)*BIT_WIDTH  pairwise masks, T[NUM_QUAD-1:0]
out_refresh_req  output  1  reseed requested (optional feature only)

Behaviour:
Interface: one clock (in_clock); in_reset is asynchronous, active-high, and clears every register immediately.

Widths and elaboration checks:
- OUT_BITS = (NUM_SHARES + num_quad(NUM_SHARES)) * BIT_WIDTH.
- Elaboration fails if OUT_BITS > 64 or WARMUP_CYCLES < 1.

LFSR step:
- One step: nb = s[63]^s[62]^s[60]^s[59]; s <= {s[62:0], nb}.
- An "advance" applies OUT_BITS steps combinationally within one cycle.

Output mapping (combinational from the state register):
- out_r[i] = s[i*BIT_WIDTH +: BIT_WIDTH].
- out_p[k] = s[(NUM_SHARES+k)*BIT_WIDTH +: BIT_WIDTH].

FSM states: S_UNSEEDED, S_LOAD, S_WARMUP, S_RUN.
- Reset: state S_UNSEEDED, s=0, warmup counter 0, out_valid=0, out_seed_ready=1, out_refresh_req=0.
- out_seed_ready=1 in S_UNSEEDED, S_LOAD and S_RUN; 0 in S_WARMUP.
- A seed transfer is in_seed_valid && out_seed_ready. Each transfer does s <= {s[31:0], in_seed}.
- S_UNSEEDED or S_RUN + transfer -> S_LOAD.
- S_LOAD + transfer -> S_WARMUP, counter cleared. If the shifted value is all zero, s[0] is forced to 1 (lock-up guard).
- S_WARMUP: one advance per cycle. After WARMUP_CYCLES advances -> S_RUN.
- S_RUN: out_valid=1. in_take && out_valid advances s, so the next word is visible the following cycle. With in_take low, outputs hold.
- A seed transfer in S_RUN beats in_take in the same cycle: the take is ignored (the word is not advanced), and out_valid=0 from the next cycle until S_RUN is re-entered.
- in_take outside S_RUN is ignored.
- Reset mid-load or mid-warmup returns to S_UNSEEDED and discards the partial seed.
- Latency: 2 seed transfers + WARMUP_CYCLES cycles -> first out_valid.

Optional Feature:
HPC1_RAND_REFRESH_EN
- With it: a draw counter runs in S_RUN and counts accepted takes.
- When the counter reaches REFRESH_PERIOD, out_refresh_req is set and held until the next seed transfer, which clears both the flag and the counter.
- Draws continue while out_refresh_req is high.
- Without it: no counter; out_refresh_req is tied to 0.

Decomposition:
- aes128_package: add RAND_LFSR_WIDTH=64, RAND_SEED_WIDTH=32 and the tap positions constant.
- The existing num_quad() is reused.
- The FSM state enum stays local to the module.
- One sub-module: lfsr_advance, parameter STEPS. It is purely combinational, maps 64-bit state to its STEPS-stepped successor, and is instantiated once with STEPS=OUT_BITS.

Test Plan:
1. Reset asserted mid-cycle -> out_valid=0, out_seed_ready=1, out_r=0, out_p=0 immediately (async).
2. Seed words 0x00000000, 0x00000000 -> state forced to 0x0000000000000001; out_valid rises exactly WARMUP_CYCLES cycles after the second transfer; outputs match a software LFSR model.
3. Seed 0x12345678, 0x9ABCDEF0, then in_take high for 100 cycles -> each cycle's out_r/out_p equals the golden model advanced OUT_BITS steps per draw.
4. In S_RUN, in_take low for 10 cycles -> out_r/out_p constant and out_valid stays 1.
5. Reseed in S_RUN with in_take high in the same cycle -> no advance; out_valid=0 next cycle; new stream matches the model seeded with the new words. Reset during S_WARMUP -> back to S_UNSEEDED.
6. With HPC1_RAND_REFRESH_EN and REFRESH_PERIOD=4: after 4 takes, out_refresh_req=1 and draws continue; the next seed transfer clears it. Without the macro, out_refresh_req stays 0.
